uc_multiciclo: RTL

- Parametrised multicycle control unit; successor to the single-cycle control unit of the monocycle CPU.
- Sequences each instruction through FETCH/DECODE/EXEC states and latches the opcode.
- Generates datapath enables and PC-select signals.
- Adds CALL/RET with a nesting-depth counter, a HALT state and a sticky stack-error flag.

---
 rtl/uc_multiciclo.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC sequencing with CALL/RET depth tracking, HALT and sticky stack error.
// Optional interrupt entry state enabled by defining UC_IRQ_EN.
module uc_multiciclo #(
  parameter int OPW         = 6,
  parameter int ALUW        = 3,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            z,
`ifdef UC_IRQ_EN
  input  logic            irq,
  output logic            irq_ack,
`endif
  output logic            ir_we,
  output logic            pc_we,
  output logic            s_inc,
  output logic            s_ret,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic [ALUW-1:0] op_alu,
  output logic            push,
  output logic            pop,
  output logic            halted,
  output logic            stack_err
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_HLT    = 3'd3;
`ifdef UC_IRQ_EN
  localparam logic [2:0] S_IRQ    = 3'd4;
`endif

  localparam logic [5:0] F_J    = 6'b110000;
  localparam logic [5:0] F_JZ   = 6'b110001;
  localparam logic [5:0] F_JNZ  = 6'b110010;
  localparam logic [5:0] F_CALL = 6'b110011;
  localparam logic [5:0] F_RET  = 6'b110100;
  localparam logic [5:0] F_HALT = 6'b111111;

  logic [2:0]     state_reg, state_next;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  depth_reg, depth_next;
  logic           stack_err_reg, stack_err_next;
  logic           halted_reg;
  logic [5:0]     f;

`ifdef UC_IRQ_EN
  logic           in_isr_reg, in_isr_next;
  logic [DW-1:0]  isr_depth_reg, isr_depth_next;
`endif

  assign f         = op_q[OPW-1 -: 6];
  assign halted    = halted_reg;
  assign stack_err = stack_err_reg;

  always_comb begin
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    s_inc          = 1'b0;
    s_ret          = 1'b0;
    s_inm          = 1'b0;
    we3            = 1'b0;
    wez            = 1'b0;
    op_alu         = '0;
    push           = 1'b0;
    pop            = 1'b0;
    state_next     = state_reg;
    depth_next     = depth_reg;
    stack_err_next = stack_err_reg;
`ifdef UC_IRQ_EN
    irq_ack        = 1'b0;
    in_isr_next    = in_isr_reg;
    isr_depth_next = isr_depth_reg;
`endif
    case (state_reg)
      S_FETCH: begin
        ir_we      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        pc_we      = 1'b1;
        state_next = S_FETCH;
        if (!f[5]) begin
          op_alu = op_q[OPW-2 -: ALUW];
          we3    = 1'b1;
          wez    = 1'b1;
          s_inc  = 1'b1;
        end else if (f[5:4] == 2'b10) begin
          we3   = 1'b1;
          s_inm = 1'b1;
          s_inc = 1'b1;
        end else begin
          case (f)
            F_J:   s_inc = 1'b0;
            F_JZ:  s_inc = ~z;
            F_JNZ: s_inc = z;
            F_CALL: begin
              if (depth_reg < DEPTH_MAX) begin
                push       = 1'b1;
                depth_next = depth_reg + 1'b1;
              end else begin
                stack_err_next = 1'b1;
                s_inc          = 1'b1;
              end
            end
            F_RET: begin
              if (depth_reg != '0) begin
                pop        = 1'b1;
                s_ret      = 1'b1;
                depth_next = depth_reg - 1'b1;
`ifdef UC_IRQ_EN
                if (in_isr_reg && depth_reg == isr_depth_reg)
                  in_isr_next = 1'b0;
`endif
              end else begin
                stack_err_next = 1'b1;
                s_inc          = 1'b1;
              end
            end
            F_HALT: begin
              pc_we      = 1'b0;
              state_next = S_HLT;
            end
            default: s_inc = 1'b1;
          endcase
        end
`ifdef UC_IRQ_EN
        // Interrupt is taken in place of the next fetch, using post-EXEC depth/ISR status.
        if (state_next == S_FETCH && irq && !in_isr_next && depth_next < DEPTH_MAX)
          state_next = S_IRQ;
`endif
      end
      S_HLT: state_next = S_HLT;
`ifdef UC_IRQ_EN
      S_IRQ: begin
        push           = 1'b1;
        pc_we          = 1'b1;
        irq_ack        = 1'b1;
        depth_next     = depth_reg + 1'b1;
        in_isr_next    = 1'b1;
        isr_depth_next = depth_reg + 1'b1;
        state_next     = S_FETCH;
      end
`endif
      default: state_next = S_FETCH;
    endcase
    // Reset forces every decoded enable low, even though the state is already FETCH.
    if (!reset) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      s_inc  = 1'b0;
      s_ret  = 1'b0;
      s_inm  = 1'b0;
      we3    = 1'b0;
      wez    = 1'b0;
      op_alu = '0;
      push   = 1'b0;
      pop    = 1'b0;
`ifdef UC_IRQ_EN
      irq_ack = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_FETCH;
      op_q          <= '0;
      depth_reg     <= '0;
      stack_err_reg <= 1'b0;
      halted_reg    <= 1'b0;
`ifdef UC_IRQ_EN
      in_isr_reg    <= 1'b0;
      isr_depth_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      if (state_reg == S_DECODE)
        op_q <= opcode;
      depth_reg     <= depth_next;
      stack_err_reg <= stack_err_next;
      halted_reg    <= (state_next == S_HLT);
`ifdef UC_IRQ_EN
      in_isr_reg    <= in_isr_next;
      isr_depth_reg <= isr_depth_next;
`endif
    end
  end

endmodule
